// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM state encoding and key layout table.
// The scanner side uses the same layout, so both ends agree on where every key sits.
package keypad_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } kp_state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } kp_pos_t;

  // Layout: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = 0 F E D
  function automatic kp_pos_t key_pos(input logic [3:0] key);
    kp_pos_t p;
    case (key)
      4'h1: p = '{2'd0, 2'd0};
      4'h2: p = '{2'd0, 2'd1};
      4'h3: p = '{2'd0, 2'd2};
      4'hA: p = '{2'd0, 2'd3};
      4'h4: p = '{2'd1, 2'd0};
      4'h5: p = '{2'd1, 2'd1};
      4'h6: p = '{2'd1, 2'd2};
      4'hB: p = '{2'd1, 2'd3};
      4'h7: p = '{2'd2, 2'd0};
      4'h8: p = '{2'd2, 2'd1};
      4'h9: p = '{2'd2, 2'd2};
      4'hC: p = '{2'd2, 2'd3};
      4'h0: p = '{2'd3, 2'd0};
      4'hF: p = '{2'd3, 2'd1};
      4'hE: p = '{2'd3, 2'd2};
      default: p = '{2'd3, 2'd3}; // 4'hD
    endcase
    return p;
  endfunction

endpackage

// File: rtl/key_to_rowcol.sv
// Combinational key value to (row, col) index lookup.
module key_to_rowcol
  import keypad_pkg::*;
(
  input  logic [3:0] key,
  output logic [1:0] row_idx,
  output logic [1:0] col_idx
);

  kp_pos_t pos;

  assign pos     = key_pos(key);
  assign row_idx = pos.row;
  assign col_idx = pos.col;

endmodule

// File: rtl/keypad_emulator.sv
// Types a latched 4-digit hex code (plus optional enter) into a matrix-keypad
// scanner by pulling the current key's row low whenever its column is strobed.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int         HOLD_CYC  = 64,
  parameter int         GAP_CYC   = 64,
  parameter logic [3:0] ENTER_KEY = 4'hE
) (
  input  logic        divclk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] code,
  input  logic        send_enter,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        busy,
  output logic        done,
  output logic [2:0]  key_idx
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  kp_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [15:0]      code_q, code_d;
  logic             enter_q, enter_d;

  logic [3:0] cur_key;
  logic [1:0] cur_row, cur_col;

  always_ff @(posedge divclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      enter_q <= enter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    code_d  = code_q;
    enter_d = enter_q;
    case (state_q)
      IDLE: if (start) begin
        code_d  = code;
        enter_d = send_enter;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = PRESS;
      end
      PRESS: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          // Last key is index 3, or 4 when the enter key is appended
          if (idx_q < (enter_q ? 3'd4 : 3'd3)) begin
            idx_d   = idx_q + 1'b1;
            state_d = PRESS;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      3'd0:    cur_key = code_q[15:12];
      3'd1:    cur_key = code_q[11:8];
      3'd2:    cur_key = code_q[7:4];
      3'd3:    cur_key = code_q[3:0];
      default: cur_key = ENTER_KEY;
    endcase
  end

  key_to_rowcol u_lookup (
    .key     (cur_key),
    .row_idx (cur_row),
    .col_idx (cur_col)
  );

  // Row follows the live column strobe so the scanner sees a wired switch
  always_comb begin
    row = 4'b1111;
    if (state_q == PRESS && !col[cur_col]) row[cur_row] = 1'b0;
  end

  assign busy    = (state_q == PRESS) || (state_q == RELEASE);
  assign done    = (state_q == DONE);
  assign key_idx = idx_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized self-checking bench for keypad_emulator against a timeline/layout model.
module tb_keypad_emulator;

  localparam int H   = 4;
  localparam int G   = 4;
  localparam int PER = H + G;

  localparam logic [3:0] LAYOUT [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  logic        divclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] code = '0;
  logic        send_enter = 1'b0;
  logic [3:0]  col = 4'hF;
  logic [3:0]  row;
  logic        busy, done;
  logic [2:0]  key_idx;

  int n_chk = 0;
  int n_fail = 0;

  keypad_emulator #(.HOLD_CYC(H), .GAP_CYC(G), .ENTER_KEY(4'hE)) dut (
    .divclk(divclk), .rst(rst), .start(start), .code(code),
    .send_enter(send_enter), .col(col), .row(row), .busy(busy),
    .done(done), .key_idx(key_idx)
  );

  always #5 divclk = ~divclk;

  function automatic logic [3:0] exp_row(input logic [3:0] key, input logic [3:0] c, input bit press);
    logic [3:0] r = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (LAYOUT[i][j] == key && press && !c[j]) r[i] = 1'b0;
    return r;
  endfunction

  task automatic step();
    @(posedge divclk); #1;
  endtask

  // Full sequence from IDLE; colmode 0 = rotating single strobe, 1 = random.
  task automatic play(input logic [15:0] c, input bit e, input int colmode,
                      input int inj_idx, input bit chk_order, input string nm);
    int nk = e ? 5 : 4;
    logic [3:0] keys [5];
    logic [3:0] got [$];
    logic [3:0] er;
    int last_k = -1;
    for (int i = 0; i < 4; i++) keys[i] = c[15-4*i -: 4];
    keys[4] = 4'hE;
    start = 1'b1; code = c; send_enter = e; col = 4'($urandom);
    @(negedge divclk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || row !== 4'hF) begin
      n_fail++;
      $display("FAIL %s idle: busy=%b done=%b row=%b, want 0 0 1111", nm, busy, done, row);
    end
    step();
    start = 1'b0; code = 16'($urandom); send_enter = 1'($urandom);
    for (int t = 0; t < nk * PER; t++) begin
      int k = t / PER;
      bit press = (t % PER) < H;
      if (k == inj_idx && (t % PER) == 0) begin
        start = 1'b1; code = ~c; send_enter = ~e;
      end else start = 1'b0;
      col = (colmode == 0) ? (4'hF & ~(4'b0001 << (t % 4))) : 4'($urandom);
      @(negedge divclk);
      er = exp_row(keys[k], col, press);
      n_chk++;
      if (row !== er || busy !== 1'b1 || done !== 1'b0 || key_idx !== 3'(k)) begin
        n_fail++;
        $display("FAIL %s t=%0d: row=%b busy=%b done=%b idx=%0d, want row=%b busy=1 done=0 idx=%0d",
                 nm, t, row, busy, done, key_idx, er, k);
      end
      if (chk_order && row !== 4'hF && k != last_k) begin
        int rr = 0, cc = 0;
        for (int i = 3; i >= 0; i--) if (!row[i]) rr = i;
        for (int j = 3; j >= 0; j--) if (!col[j]) cc = j;
        got.push_back(LAYOUT[rr][cc]);
        last_k = k;
      end
      step();
    end
    start = 1'b0; col = 4'($urandom);
    @(negedge divclk);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || row !== 4'hF) begin
      n_fail++;
      $display("FAIL %s done: done=%b busy=%b row=%b, want 1 0 1111", nm, done, busy, row);
    end
    if (chk_order) begin
      n_chk++;
      if (got.size() != nk) begin
        n_fail++;
        $display("FAIL %s order: decoded %0d keys, want %0d", nm, got.size(), nk);
      end else begin
        for (int i = 0; i < nk; i++)
          if (got[i] !== keys[i]) begin
            n_fail++;
            $display("FAIL %s order: key %0d = %h, want %h", nm, i, got[i], keys[i]);
            break;
          end
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; col = 4'b0000;
    repeat (3) step();
    @(negedge divclk);
    n_chk++;
    if (row !== 4'hF || busy !== 1'b0 || done !== 1'b0 || key_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset: row=%b busy=%b done=%b idx=%0d, want 1111 0 0 0", row, busy, done, key_idx);
    end
    step();
    rst = 1'b0; start = 1'b0;
    step();
  endtask

  task automatic test_basic();
    play(16'h1234, 1'b0, 0, -1, 1'b1, "basic_1234");
  endtask

  task automatic test_enter();
    play(16'h0FED, 1'b1, 0, -1, 1'b1, "enter_0fed");
  endtask

  task automatic test_start_ignored();
    play(16'h5A7C, 1'b0, 1, 2, 1'b0, "start_ignored");
  endtask

  task automatic test_rst_midpress();
    start = 1'b1; code = 16'h1234; send_enter = 1'b0;
    step();
    start = 1'b0;
    step();
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; col = 4'b0000;
    @(negedge divclk);
    n_chk++;
    if (row !== 4'hF || busy !== 1'b0 || done !== 1'b0 || key_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid: row=%b busy=%b done=%b idx=%0d, want 1111 0 0 0", row, busy, done, key_idx);
    end
    for (int i = 0; i < 3 * PER; i++) begin
      step();
      col = 4'($urandom);
      @(negedge divclk);
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0 || row !== 4'hF) begin
        n_fail++;
        $display("FAIL rst_idle c%0d: done=%b busy=%b row=%b, want 0 0 1111", i, done, busy, row);
      end
    end
    step();
  endtask

  task automatic test_col_patterns();
    start = 1'b1; code = 16'h5000; send_enter = 1'b0;
    step();
    start = 1'b0; col = 4'b0000;
    @(negedge divclk);
    n_chk++;
    if (row !== 4'b1101) begin
      n_fail++; $display("FAIL col_all_low: row=%b, want 1101", row);
    end
    step();
    col = 4'b1111;
    @(negedge divclk);
    n_chk++;
    if (row !== 4'b1111) begin
      n_fail++; $display("FAIL col_none: row=%b, want 1111", row);
    end
    repeat (H - 1) step();
    col = 4'b1101;
    @(negedge divclk);
    n_chk++;
    if (row !== 4'b1111 || busy !== 1'b1) begin
      n_fail++; $display("FAIL col_release: row=%b busy=%b, want 1111 1", row, busy);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    play(16'($urandom), 1'b1, 1, -1, 1'b0, "b2b_first");
    play(16'hABCD, 1'b0, 0, -1, 1'b1, "b2b_abcd");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      play(16'($urandom), 1'($urandom), 1, int'($urandom_range(0, 5)), 1'b0, "random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enter();
    test_start_ignored();
    test_rst_midpress();
    test_col_patterns();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 64: divclk cycles each key is held pressed, legal range 1..1023.
REQ-002 SHALL have parameter GAP_CYC, default 64: divclk cycles of all-released gap after each key, legal range 1..1023.
REQ-003 SHALL have parameter ENTER_KEY, default 4'hE: key value typed after the four digits when send_enter=1.
REQ-004 SHALL have port divclk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  request to type code; sampled only in IDLE.
REQ-007 SHALL have port code  input  16  four hex digits, typed code[15:12] first, code[3:0] last.
REQ-008 SHALL have port send_enter  input  1  append ENTER_KEY as fifth key.
REQ-009 SHALL have port col  input  4  active-low column strobes from the keypad scanner.
REQ-010 SHALL have port row  output  4  active-low row returns; 4'b1111 = no key.
REQ-011 SHALL have port busy  output  1  high while typing (PRESS/RELEASE).
REQ-012 SHALL have port done  output  1  one-cycle pulse when the sequence completes.
REQ-013 SHALL have port key_idx  output  3  index of the key currently being typed, 0..4.

Function
REQ-014 SHALL implement FSM states IDLE, PRESS, RELEASE, DONE.
REQ-015 SHALL, in IDLE with start=1, latch code and send_enter, set key_idx=0, clear the counter and enter PRESS on the next edge.
REQ-016 SHALL ignore start in any state other than IDLE; latched code SHALL not change mid-sequence.
REQ-017 SHALL remain in PRESS for exactly HOLD_CYC cycles, then enter RELEASE.
REQ-018 SHALL remain in RELEASE for exactly GAP_CYC cycles, then enter PRESS with key_idx+1 if keys remain, else enter DONE.
REQ-019 SHALL type 4 keys when latched send_enter=0 and 5 keys (last = ENTER_KEY) when 1.
REQ-020 SHALL stay in DONE for one cycle with done=1, then return to IDLE.
REQ-021 SHALL drive busy=1 exactly in PRESS and RELEASE; done=1 exactly in DONE.
REQ-022 SHALL map keys to (row,col) by the layout: row0 = 1 2 3 A; row1 = 4 5 6 B; row2 = 7 8 9 C; row3 = 0 F E D; col index 0..3 left to right.
REQ-023 SHALL compute row combinationally from col and registered state: in PRESS, row[r]=0 iff col[c]=0 for the current key at (r,c); all other row bits 1.
REQ-024 SHALL drive row=4'b1111 in IDLE, RELEASE and DONE regardless of col.
REQ-025 SHALL, when several col bits are low in PRESS, assert the current key's row if its column is among them (wired-keypad behaviour).
REQ-026 SHALL drive row=4'b1111 when col=4'b1111.
REQ-027 SHALL size the hold/gap counter to 10 bits; no wrap-around within legal parameter range.
REQ-028 SHALL accept a start in IDLE on the cycle immediately after DONE (back-to-back sequences).

Reset
REQ-029 SHALL, on rst=1 at a divclk edge, enter IDLE, clear counter, key_idx=0, busy=0, done=0, latched code=16'h0000, latched send_enter=0.
REQ-030 SHALL give rst priority over start and over any in-progress sequence; row SHALL read 4'b1111 from the cycle after reset is sampled, with no done pulse.

Structure
REQ-031 SHALL place the keypad layout table (key value -> row/col index) and the state encoding in shared package keypad_pkg, reused by the scanner side.
REQ-032 SHALL implement the layout lookup as sub-module key_to_rowcol (4-bit key in, 2-bit row and 2-bit col out, combinational).

Verification
REQ-033 SHALL cover: HOLD_CYC=4, GAP_CYC=4, code=16'h1234, send_enter=0, scanner rotating col -> keys 1,2,3,4 decoded in order; busy high 32 cycles; done one pulse after.
REQ-034 SHALL cover: code=16'h0FED, send_enter=1 -> rows 3,3,3,3 at cols 0,1,2,3 then ENTER_KEY E (row3,col2); key_idx 0..4; done once.
REQ-035 SHALL cover: start pulsed at key_idx=2 of a running sequence with a different code -> ignored, original digits completed.
REQ-036 SHALL cover: rst asserted in PRESS of key 1 -> next cycle IDLE, row=4'b1111, busy=0, no done pulse.
REQ-037 SHALL cover: col=4'b0000 during PRESS of key 5 -> row=4'b1101; col=4'b1111 -> row=4'b1111; col=4'b1101 in RELEASE -> row=4'b1111.
REQ-038 SHALL cover: start asserted in the cycle after DONE with code=16'hABCD -> new sequence begins with no idle gap beyond one IDLE cycle.
